// File: rtl/mar_bank.sv
// mar_bank: bank of WIDTH-bit address registers, loaded chunk-wise from a gated strobe, with inc/dec and wrap flag.
// Define MAR_BANK_SATURATE_EN to make inc/dec saturate at the range limits instead of wrapping.
module mar_bank #(
   parameter int WIDTH    = 8,
   parameter int DIN_W    = 4,
   parameter int NUM_REGS = 4,
   localparam int SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIN_W-1:0] d_in,
   input  logic [SEL_W-1:0] sel,
   input  logic             g,
   input  logic             g1_n,
   input  logic             g2_n,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             load_busy,
   output logic             wrap
);
   localparam int NCHUNK = WIDTH / DIN_W;
   localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   logic [WIDTH-1:0]    r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_valid;
   logic [PTR_W-1:0]    r_ptr;
   logic [SEL_W-1:0]    r_sel_q;
   logic                r_stb_q;
   logic [WIDTH-1:0]    r_q;
   logic                r_q_valid, r_load_busy, r_wrap;
   logic                w_stb, w_sel_ok, w_sel_chg, w_ld, w_last, w_step, w_lim;
   logic [SEL_W-1:0]    w_si;
   logic [PTR_W-1:0]    w_idx;
   logic [WIDTH-1:0]    w_cur, w_next;
   assign w_stb     = g & ~g1_n & ~g2_n;
   assign w_sel_ok  = {1'b0, sel} < (SEL_W+1)'(NUM_REGS);
   assign w_si      = w_sel_ok ? sel : '0;
   assign w_sel_chg = sel != r_sel_q;
   assign w_ld      = w_stb & ~r_stb_q & w_sel_ok;
   // a load that coincides with a select change starts the new register at chunk 0
   assign w_idx     = w_sel_chg ? '0 : r_ptr;
   assign w_last    = w_idx == PTR_W'(NCHUNK - 1);
   assign w_cur     = r_regs[w_si];
   assign w_step    = ~w_ld & w_sel_ok & (inc ^ dec);
   assign w_lim     = inc ? &w_cur : ~|w_cur;
`ifdef MAR_BANK_SATURATE_EN
   assign w_next    = w_lim ? w_cur : (inc ? w_cur + 1'b1 : w_cur - 1'b1);
`else
   assign w_next    = inc ? w_cur + 1'b1 : w_cur - 1'b1;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_valid     <= '0;
         r_ptr       <= '0;
         r_sel_q     <= '0;
         r_stb_q     <= 1'b0;
         r_q         <= '0;
         r_q_valid   <= 1'b0;
         r_load_busy <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_stb_q     <= w_stb;
         r_sel_q     <= sel;
         r_q         <= w_sel_ok ? w_cur : '0;
         r_q_valid   <= w_sel_ok & r_valid[w_si];
         r_load_busy <= r_ptr != '0;
         r_wrap      <= w_step & w_lim;
         if (w_ld) begin
            r_regs[w_si][int'(w_idx)*DIN_W +: DIN_W] <= d_in;
            r_ptr <= w_last ? '0 : w_idx + 1'b1;
            if (w_last) r_valid[w_si] <= 1'b1;
         end else begin
            if (w_sel_chg) r_ptr <= '0;
            if (w_step) r_regs[w_si] <= w_next;
         end
      end
   end
   assign q         = r_q;
   assign q_valid   = r_q_valid;
   assign load_busy = r_load_busy;
   assign wrap      = r_wrap;
endmodule
